factor_quiz_ctrl: RTL and testbench

Game controller for the prime-factor quiz; sits directly upstream of the 7-segment decoder stage and drives its STATE, QUE and DIN (SEG_Q) inputs. It sequences READY → QUESTION → INPUT → judge → next question over 10 questions. It takes single-cycle, already-debounced button pulses, tracks the player's prime selection, compares it against a fixed answer ROM, and counts the score.

---
 rtl/factor_quiz_ctrl_if.sv | 33 +++
 rtl/factor_quiz_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_factor_quiz_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/factor_quiz_ctrl_if.sv
// factor_quiz_ctrl_if
// Groups the quiz controller's button inputs and display/score outputs.
//   master : button driver side (drives btn_*, observes game outputs)
//   slave  : the controller (samples btn_*, drives game outputs)
// Signals:
//   btn_start, btn_next, btn_enter : single-cycle debounced button pulses
//   state[3:0] : game state code to the 7-segment decoder
//   que[3:0]   : current question index 0-9
//   seg_q[3:0] : selection index 0-9, 0 = nothing selected
//   score[3:0] : correct answers 0-10
//   led_ok     : high while state = CORRECT
//   led_ng     : high while state = WRONG
interface factor_quiz_ctrl_if;
  logic       btn_start;
  logic       btn_next;
  logic       btn_enter;
  logic [3:0] state;
  logic [3:0] que;
  logic [3:0] seg_q;
  logic [3:0] score;
  logic       led_ok;
  logic       led_ng;

  modport master (
    output btn_start, btn_next, btn_enter,
    input  state, que, seg_q, score, led_ok, led_ng
  );

  modport slave (
    input  btn_start, btn_next, btn_enter,
    output state, que, seg_q, score, led_ok, led_ng
  );
endinterface

// File: rtl/factor_quiz_ctrl.sv
// factor_quiz_ctrl
// Game sequencer for the prime-factor quiz. Runs READY -> QUESTION -> INPUT
// -> CORRECT/WRONG over ten questions, tracks the player's prime selection,
// judges it against a fixed answer ROM and keeps the score. All outputs are
// registered.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : factor_quiz_ctrl_if.slave (buttons in, state/que/seg_q/score/leds out)
// Parameters:
//   QUE_CYCLES    : cycles spent in QUESTION
//   RESULT_CYCLES : cycles spent in CORRECT / WRONG
//   INPUT_CYCLES  : INPUT timeout, only used with FACTOR_QUIZ_TIMEOUT_EN
// Build option:
//   FACTOR_QUIZ_TIMEOUT_EN : when defined, INPUT times out to WRONG after
//                            INPUT_CYCLES cycles without an accepted ENTER.
//
// state    | meaning
// ---------+-----------------------------------------------
// READY    | idle, waiting for START
// QUESTION | question shown for QUE_CYCLES
// INPUT    | player selects a prime with NEXT, submits with ENTER
// CORRECT  | answer matched, shown for RESULT_CYCLES
// WRONG    | answer mismatched (or timed out), RESULT_CYCLES
// DONE     | all ten questions played, final score held
module factor_quiz_ctrl #(
  parameter int QUE_CYCLES    = 50_000_000,
  parameter int RESULT_CYCLES = 50_000_000,
  parameter int INPUT_CYCLES  = 500_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  factor_quiz_ctrl_if.slave    bus
);

  localparam int MAX_AB = (QUE_CYCLES > RESULT_CYCLES) ? QUE_CYCLES : RESULT_CYCLES;
  localparam int MAX_C  = (MAX_AB > INPUT_CYCLES) ? MAX_AB : INPUT_CYCLES;
  localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] QUE_TC = CW'(QUE_CYCLES - 1);
  localparam logic [CW-1:0] RES_TC = CW'(RESULT_CYCLES - 1);
`ifdef FACTOR_QUIZ_TIMEOUT_EN
  localparam logic [CW-1:0] IN_TC  = CW'(INPUT_CYCLES - 1);
`endif

  typedef enum logic [3:0] {
    READY    = 4'b0010,
    QUESTION = 4'b0011,
    INPUT    = 4'b0100,
    CORRECT  = 4'b0101,
    WRONG    = 4'b0110,
    DONE     = 4'b0111
  } state_t;

  state_t        st;
  logic [3:0]    que;
  logic [3:0]    seg_q;
  logic [3:0]    score;
  logic          led_ok;
  logic          led_ng;
  logic [CW-1:0] cnt;

  // Smallest prime factor of each question's N, as a selection index.
  function automatic logic [3:0] answer(input logic [3:0] q);
    case (q)
      4'd0:    answer = 4'd1;
      4'd1:    answer = 4'd2;
      4'd2:    answer = 4'd3;
      4'd3:    answer = 4'd4;
      4'd4:    answer = 4'd5;
      4'd5:    answer = 4'd6;
      4'd6:    answer = 4'd7;
      4'd7:    answer = 4'd8;
      4'd8:    answer = 4'd9;
      4'd9:    answer = 4'd4;
      default: answer = 4'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= READY;
      que    <= 4'd0;
      seg_q  <= 4'd0;
      score  <= 4'd0;
      led_ok <= 1'b0;
      led_ng <= 1'b0;
      cnt    <= '0;
    end else begin
      case (st)
        READY: begin
          if (bus.btn_start) begin
            st    <= QUESTION;
            que   <= 4'd0;
            seg_q <= 4'd0;
            score <= 4'd0;
            cnt   <= '0;
          end
        end

        QUESTION: begin
          if (cnt == QUE_TC) begin
            st    <= INPUT;
            seg_q <= 4'd0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        INPUT: begin
          // An ENTER with nothing selected is not accepted, so a NEXT in
          // the same cycle still advances the selection.
          if (bus.btn_enter && (seg_q != 4'd0)) begin
            cnt <= '0;
            if (seg_q == answer(que)) begin
              st     <= CORRECT;
              led_ok <= 1'b1;
              if (score < 4'd10) score <= score + 4'd1;
            end else begin
              st     <= WRONG;
              led_ng <= 1'b1;
            end
          end
`ifdef FACTOR_QUIZ_TIMEOUT_EN
          else if (cnt == IN_TC) begin
            st     <= WRONG;
            led_ng <= 1'b1;
            cnt    <= '0;
          end
`endif
          else begin
            if (bus.btn_next) seg_q <= (seg_q == 4'd9) ? 4'd1 : seg_q + 4'd1;
`ifdef FACTOR_QUIZ_TIMEOUT_EN
            cnt <= cnt + 1'b1;
`endif
          end
        end

        CORRECT, WRONG: begin
          if (cnt == RES_TC) begin
            cnt    <= '0;
            led_ok <= 1'b0;
            led_ng <= 1'b0;
            if (que == 4'd9) begin
              st <= DONE;
            end else begin
              st    <= QUESTION;
              que   <= que + 4'd1;
              seg_q <= 4'd0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          if (bus.btn_start) begin
            st  <= READY;
            cnt <= '0;
          end
        end

        default: begin
          st     <= READY;
          led_ok <= 1'b0;
          led_ng <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

  assign bus.state  = st;
  assign bus.que    = que;
  assign bus.seg_q  = seg_q;
  assign bus.score  = score;
  assign bus.led_ok = led_ok;
  assign bus.led_ng = led_ng;

endmodule

// File: tb/tb_factor_quiz_ctrl.sv
// tb_factor_quiz_ctrl
// Directed bench for factor_quiz_ctrl with QUE_CYCLES=4, RESULT_CYCLES=3,
// INPUT_CYCLES=20. Inputs change and outputs are sampled on the falling edge.
// Covers the FACTOR_QUIZ_TIMEOUT_EN build when that macro is defined.
module tb_factor_quiz_ctrl;

  localparam logic [3:0] S_READY    = 4'b0010;
  localparam logic [3:0] S_QUESTION = 4'b0011;
  localparam logic [3:0] S_INPUT    = 4'b0100;
  localparam logic [3:0] S_CORRECT  = 4'b0101;
  localparam logic [3:0] S_WRONG    = 4'b0110;
  localparam logic [3:0] S_DONE     = 4'b0111;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   rom[10]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 4};

  factor_quiz_ctrl_if bus ();

  factor_quiz_ctrl #(
    .QUE_CYCLES   (4),
    .RESULT_CYCLES(3),
    .INPUT_CYCLES (20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit s, input bit n, input bit e);
    bus.btn_start = s;
    bus.btn_next  = n;
    bus.btn_enter = e;
    @(negedge clk);
    bus.btn_start = 1'b0;
    bus.btn_next  = 1'b0;
    bus.btn_enter = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, {4'd0, bus.state}, {4'd0, S_READY});
    chk({tag, "_que"},   {4'd0, bus.que},   8'd0);
    chk({tag, "_seg"},   {4'd0, bus.seg_q}, 8'd0);
    chk({tag, "_score"}, {4'd0, bus.score}, 8'd0);
    chk({tag, "_ok"},    {7'd0, bus.led_ok}, 8'd0);
    chk({tag, "_ng"},    {7'd0, bus.led_ng}, 8'd0);
  endtask

  // Called right after QUESTION for question q was entered; answers with
  // index a and runs through the result display.
  task automatic play(input int q, input int a, input bit ok, input int sc);
    idle(3);
    chk("play_q_hold", {4'd0, bus.state}, {4'd0, S_QUESTION});
    idle(1);
    chk("play_input", {4'd0, bus.state}, {4'd0, S_INPUT});
    repeat (a) step(1'b0, 1'b1, 1'b0);
    chk("play_seg", {4'd0, bus.seg_q}, 8'(a));
    step(1'b0, 1'b0, 1'b1);
    chk("play_judge", {4'd0, bus.state}, ok ? {4'd0, S_CORRECT} : {4'd0, S_WRONG});
    chk("play_score", {4'd0, bus.score}, 8'(sc));
    idle(3);
    if (q == 9) begin
      chk("play_done", {4'd0, bus.state}, {4'd0, S_DONE});
    end else begin
      chk("play_next_state", {4'd0, bus.state}, {4'd0, S_QUESTION});
      chk("play_next_que",   {4'd0, bus.que},   8'(q + 1));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.btn_start = 1'b0;
    bus.btn_next  = 1'b0;
    bus.btn_enter = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    step(1'b0, 1'b1, 1'b1);
    chk("ready_ignore_btn", {4'd0, bus.state}, {4'd0, S_READY});
    chk("ready_ignore_seg", {4'd0, bus.seg_q}, 8'd0);

    // QUESTION lasts exactly 4 cycles.
    step(1'b1, 1'b0, 1'b0);
    chk("start_state", {4'd0, bus.state}, {4'd0, S_QUESTION});
    chk("start_que",   {4'd0, bus.que},   8'd0);
    chk("start_score", {4'd0, bus.score}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("question_hold", {4'd0, bus.state}, {4'd0, S_QUESTION});
    end
    idle(1);
    chk("question_to_input", {4'd0, bus.state}, {4'd0, S_INPUT});
    chk("input_seg0",        {4'd0, bus.seg_q}, 8'd0);

    // Q0: ENTER with no selection, START, both ignored.
    step(1'b0, 1'b0, 1'b1);
    chk("enter_seg0_state", {4'd0, bus.state}, {4'd0, S_INPUT});
    step(1'b1, 1'b0, 1'b0);
    chk("start_in_input",   {4'd0, bus.state}, {4'd0, S_INPUT});
    step(1'b0, 1'b1, 1'b0);
    chk("q0_seg", {4'd0, bus.seg_q}, 8'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("q0_correct", {4'd0, bus.state}, {4'd0, S_CORRECT});
    chk("q0_led_ok",  {7'd0, bus.led_ok}, 8'd1);
    chk("q0_led_ng",  {7'd0, bus.led_ng}, 8'd0);
    chk("q0_score",   {4'd0, bus.score}, 8'd1);
    idle(2);
    chk("q0_result_hold", {4'd0, bus.state}, {4'd0, S_CORRECT});
    idle(1);
    chk("q0_next_state", {4'd0, bus.state}, {4'd0, S_QUESTION});
    chk("q0_next_que",   {4'd0, bus.que},   8'd1);
    chk("q0_next_ok",    {7'd0, bus.led_ok}, 8'd0);

    // Q1: NEXT wraps 9 -> 1, never back to 0.
    idle(4);
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("q1_next_seq", {4'd0, bus.seg_q}, 8'((i % 9) + 1));
    end
    step(1'b0, 1'b0, 1'b1);
    chk("q1_correct", {4'd0, bus.state}, {4'd0, S_CORRECT});
    chk("q1_score",   {4'd0, bus.score}, 8'd2);
    idle(3);
    chk("q1_next_que", {4'd0, bus.que}, 8'd2);

    // Q2: NEXT and ENTER together -> judged on seg 1 (answer 3) -> WRONG.
    idle(4);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    chk("q2_wrong",  {4'd0, bus.state}, {4'd0, S_WRONG});
    chk("q2_seg",    {4'd0, bus.seg_q}, 8'd1);
    chk("q2_led_ng", {7'd0, bus.led_ng}, 8'd1);
    chk("q2_led_ok", {7'd0, bus.led_ok}, 8'd0);
    chk("q2_score",  {4'd0, bus.score}, 8'd2);
    idle(3);
    chk("q2_next_que", {4'd0, bus.que}, 8'd3);

    for (int q = 3; q < 10; q++) play(q, rom[q], 1'b1, q);
    chk("g1_done_score", {4'd0, bus.score}, 8'd9);
    chk("g1_done_que",   {4'd0, bus.que},   8'd9);
    chk("g1_done_seg",   {4'd0, bus.seg_q}, 8'd4);
    step(1'b0, 1'b1, 1'b1);
    chk("done_ignore_state", {4'd0, bus.state}, {4'd0, S_DONE});
    chk("done_ignore_seg",   {4'd0, bus.seg_q}, 8'd4);
    step(1'b1, 1'b0, 1'b0);
    chk("done_to_ready", {4'd0, bus.state}, {4'd0, S_READY});
    chk("ready_keeps_score", {4'd0, bus.score}, 8'd9);
    step(1'b1, 1'b0, 1'b0);
    chk("restart_state", {4'd0, bus.state}, {4'd0, S_QUESTION});
    chk("restart_score", {4'd0, bus.score}, 8'd0);
    chk("restart_que",   {4'd0, bus.que},   8'd0);

    // Full game, all correct.
    for (int q = 0; q < 10; q++) play(q, rom[q], 1'b1, q + 1);
    chk("g2_done_score", {4'd0, bus.score}, 8'd10);
    chk("g2_done_que",   {4'd0, bus.que},   8'd9);
    step(1'b1, 1'b0, 1'b0);
    chk("g2_ready", {4'd0, bus.state}, {4'd0, S_READY});
    step(1'b1, 1'b0, 1'b0);
    chk("g2_restart_score", {4'd0, bus.score}, 8'd0);
    chk("g2_restart_que",   {4'd0, bus.que},   8'd0);

    // Async reset while CORRECT at Q5.
    for (int q = 0; q < 5; q++) play(q, rom[q], 1'b1, q + 1);
    idle(4);
    repeat (6) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("q5_correct", {4'd0, bus.state}, {4'd0, S_CORRECT});
    chk("q5_score",   {4'd0, bus.score}, 8'd6);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0);
    chk("post_rst_state", {4'd0, bus.state}, {4'd0, S_QUESTION});
    chk("post_rst_que",   {4'd0, bus.que},   8'd0);
    chk("post_rst_score", {4'd0, bus.score}, 8'd0);
    idle(4);
    chk("timeout_input", {4'd0, bus.state}, {4'd0, S_INPUT});

`ifdef FACTOR_QUIZ_TIMEOUT_EN
    idle(19);
    chk("timeout_hold",  {4'd0, bus.state}, {4'd0, S_INPUT});
    idle(1);
    chk("timeout_wrong", {4'd0, bus.state}, {4'd0, S_WRONG});
    chk("timeout_score", {4'd0, bus.score}, 8'd0);
    idle(3);
    chk("timeout_next_que", {4'd0, bus.que}, 8'd1);
    idle(4);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    idle(17);
    chk("timeout_edge_hold", {4'd0, bus.state}, {4'd0, S_INPUT});
    step(1'b0, 1'b0, 1'b1);
    chk("enter_on_timeout", {4'd0, bus.state}, {4'd0, S_CORRECT});
    chk("enter_on_timeout_score", {4'd0, bus.score}, 8'd1);
`else
    idle(100);
    chk("no_timeout_state", {4'd0, bus.state}, {4'd0, S_INPUT});
    chk("no_timeout_score", {4'd0, bus.score}, 8'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
